// File: rtl/perf_counter_pkg.sv
// Shared types and helpers for the performance-counter bank.
package perf_counter_pkg;

    localparam int MAX_NUM_CH = 16;
    localparam int MAX_CNT_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] val,
        input logic [MAX_CNT_W-1:0] max_val
    );
        return (val >= max_val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating counter with clear, enable and a sticky overflow flag.
module perf_sat_counter
    import perf_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [MAX_CNT_W-1:0] MAX_V = MAX_CNT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            // an attempt at the ceiling is the overflow event
            if (&cnt_q) ovf_d = 1'b1;
            cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(cnt_q), MAX_V));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle/event counter bank with a run-cycle budget.
// PERF_SNAPSHOT_EN adds snapshot registers that rd_data_o reads once captured.
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 64,
    parameter int          SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              clear_i,
    input  logic              snap_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              snap_valid_o,
    output logic              done_o
);

    perf_state_e state_q, state_d;

    logic                         cnt_en;
    logic                         last_cyc;
    logic [CNT_W-1:0]             cycle_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
    logic [CNT_W-1:0]             live_rd;

    always_comb begin
        cnt_en   = (state_q == RUN) && start_i;
        last_cyc = cnt_en && (MAX_CYCLES != 0) &&
                   (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
        state_d  = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_cyc) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (cnt_en),
        .cnt_o (cycle_cnt),
        .ovf_o ()
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        perf_sat_counter #(.CNT_W(CNT_W)) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .en_i  (cnt_en & event_i[k]),
            .cnt_o (ch_cnt[k]),
            .ovf_o (ovf_o[k])
        );
    end

    always_comb begin
        live_rd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(k)) live_rd = ch_cnt[k];
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] snap_q, snap_d;
    logic                         snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]             snap_rd;

    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        if (clear_i) begin
            snap_d       = '0;
            snap_valid_d = 1'b0;
        end else if (snap_i) begin
            snap_d       = ch_cnt;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    always_comb begin
        snap_rd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(k)) snap_rd = snap_q[k];
        end
    end

    assign rd_data_o    = snap_valid_q ? snap_rd : live_rd;
    assign snap_valid_o = snap_valid_q;
`else
    assign rd_data_o    = live_rd;
    assign snap_valid_o = 1'b0;
`endif

    assign cycle_o = cycle_cnt;
    assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed checks of perf_counter_bank: budget, pause, saturation, clear, snapshot, reset.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, snap;
    logic [3:0]  ev;
    logic [1:0]  sel;
    logic [31:0] rd, cyc;
    logic [3:0]  ovf;
    logic        sv, done;

    logic        s_rst, s_start, s_clear, s_snap;
    logic [3:0]  s_ev;
    logic [1:0]  s_sel;
    logic [3:0]  s_rd, s_cyc;
    logic [3:0]  s_ovf;
    logic        s_sv, s_done;

    int checks   = 0;
    int failures = 0;

    perf_counter_bank dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev),
        .clear_i(clear), .snap_i(snap), .rd_sel_i(sel),
        .rd_data_o(rd), .cycle_o(cyc), .ovf_o(ovf),
        .snap_valid_o(sv), .done_o(done)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .MAX_CYCLES(0)) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .event_i(s_ev),
        .clear_i(s_clear), .snap_i(s_snap), .rd_sel_i(s_sel),
        .rd_data_o(s_rd), .cycle_o(s_cyc), .ovf_o(s_ovf),
        .snap_valid_o(s_sv), .done_o(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_ch(input logic [1:0] s, output logic [31:0] v);
        sel = s;
        #1;
        v = rd;
    endtask

    task automatic do_clear();
        clear = 1'b1; start = 1'b0; ev = '0; snap = 1'b0;
        step(1);
        clear = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; ev = '0; sel = '0;
        s_rst = 1'b1; s_start = 1'b0; s_clear = 1'b0; s_snap = 1'b0;
        s_ev = '0; s_sel = 2'd2;
        step(2);
        rst = 1'b0; s_rst = 1'b0;

        check("rst_cycle", cyc, 0);
        check("rst_rd", rd, 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_snapv", 32'(sv), 0);
        check("rst_done", 32'(done), 0);

        // budget stop
        start = 1'b1; ev = 4'b0001;
        step(1);
        check("entry_no_count", cyc, 0);
        step(63);
        check("b63_cycle", cyc, 63);
        check("b63_done", 32'(done), 0);
        step(1);
        check("b64_done", 32'(done), 1);
        check("b64_cycle", cyc, 64);
        read_ch(0, v); check("b64_ch0", v, 64);
        read_ch(1, v); check("b64_ch1", v, 0);
        read_ch(3, v); check("b64_ch3", v, 0);
        ev = 4'hF;
        step(10);
        check("frozen_cycle", cyc, 64);
        read_ch(0, v); check("frozen_ch0", v, 64);
        read_ch(2, v); check("frozen_ch2", v, 0);
        check("frozen_done", 32'(done), 1);

        // pause
        do_clear();
        check("clr_cycle", cyc, 0);
        check("clr_done", 32'(done), 0);
        start = 1'b1; ev = 4'b0010;
        step(1);
        step(20);
        check("p20_cycle", cyc, 20);
        start = 1'b0;
        step(5);
        check("pause_hold", cyc, 20);
        read_ch(1, v); check("pause_ch1", v, 20);
        start = 1'b1;
        step(44);
        check("p_done", 32'(done), 1);
        check("p_cycle", cyc, 64);
        read_ch(1, v); check("p_ch1", v, 64);
        read_ch(0, v); check("p_ch0", v, 0);

        // clear collision
        do_clear();
        start = 1'b1; ev = 4'hF;
        step(1);
        step(30);
        check("cc_cycle30", cyc, 30);
        clear = 1'b1; snap = 1'b1;
        step(1);
        clear = 1'b0; snap = 1'b0;
        check("cc_cycle", cyc, 0);
        check("cc_ovf", 32'(ovf), 0);
        check("cc_snapv", 32'(sv), 0);
        for (int k = 0; k < 4; k++) begin
            read_ch(2'(k), v);
            check($sformatf("cc_ch%0d", k), v, 0);
        end
        step(1);
        check("cc_idle_entry", cyc, 0);
        step(1);
        check("cc_first_count", cyc, 1);

        // snapshot
        do_clear();
        start = 1'b1; ev = 4'b0001;
        step(1);
        step(10);
        check("sn_cycle10", cyc, 10);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(5);
        check("sn_cycle", cyc, 16);
        read_ch(0, v);
`ifdef PERF_SNAPSHOT_EN
        check("sn_rd", v, 10);
        check("sn_valid", 32'(sv), 1);
`else
        check("sn_rd", v, 16);
        check("sn_valid", 32'(sv), 0);
`endif
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(3);
        read_ch(0, v);
`ifdef PERF_SNAPSHOT_EN
        check("sn2_rd", v, 16);
`else
        check("sn2_rd", v, 20);
`endif

        // reset mid-run
        do_clear();
        start = 1'b1; ev = 4'b0001;
        step(1);
        step(40);
        check("rm_cycle40", cyc, 40);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        read_ch(0, v);
        check("rm_rd", v, 0);
        check("rm_cycle", cyc, 0);
        check("rm_ovf", 32'(ovf), 0);
        check("rm_snapv", 32'(sv), 0);
        check("rm_done", 32'(done), 0);
        step(1);
        step(63);
        check("rm63_done", 32'(done), 0);
        step(1);
        check("rm64_done", 32'(done), 1);
        check("rm64_cycle", cyc, 64);

        // saturation on the narrow instance
        s_start = 1'b1; s_ev = 4'b0100;
        step(1);
        step(15);
        check("sat15_ch2", 32'(s_rd), 15);
        check("sat15_ovf", 32'(s_ovf), 0);
        step(5);
        check("sat_ch2", 32'(s_rd), 15);
        check("sat_ovf", 32'(s_ovf), 32'h4);
        check("sat_cycle", 32'(s_cyc), 15);
        check("sat_done", 32'(s_done), 0);
        s_sel = 2'd0;
        #1;
        check("sat_ch0", 32'(s_rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
